// File: rtl/apb_mem_param.sv
`timescale 1ns/1ps
// apb_mem_param: parametrised APB3 scratch-RAM slave with per-transfer wait
// states taken from PWAIT and PSLVERR for word addresses outside
// BASE_ADDR..BASE_ADDR+DEPTH-1.
// Optional build macro APB_MEM_PSTRB_EN adds the APB4 PSTRB byte-strobe input.
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a setup cycle
// ACCESS | access phase, counting down wait states until PREADY
module apb_mem_param #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10,
    parameter int                WAIT_W    = 4
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [WAIT_W-1:0]   PWAIT,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Range limits are held one bit wider than PADDR so BASE_ADDR+DEPTH-1
    // can never wrap around and make an out-of-range address look valid.
    localparam logic [ADDR_W:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] ADDR_HI = ADDR_LO + (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [NB-1:0]       wstrb;

`ifdef APB_MEM_PSTRB_EN
    logic [NB-1:0]       strb_q, strb_d;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W:0]     paddr_x;
    logic [ADDR_W:0]     offset;
    logic [IDX_W-1:0]    idx_in;
    logic                addr_err;
    logic                ready;
    logic                complete;
    logic                mem_we;
    logic                unused_offset_hi;

    assign paddr_x          = {1'b0, PADDR};
    assign addr_err         = (paddr_x < ADDR_LO) || (paddr_x > ADDR_HI);
    assign offset           = paddr_x - ADDR_LO;
    assign idx_in           = offset[IDX_W-1:0];
    assign unused_offset_hi = ^offset[ADDR_W:IDX_W];

    // PREADY/PSLVERR come from registers only, never from bus inputs.
    assign ready    = (state_q == ACCESS) && (cnt_q == '0);
    assign complete = ready && PSEL && PENABLE;
    assign mem_we   = complete && write_q && !err_q;

    assign PREADY   = ready;
    assign PSLVERR  = ready && err_q;
    assign PRDATA   = prdata_q;

`ifdef APB_MEM_PSTRB_EN
    assign wstrb = strb_q;
`else
    assign wstrb = '1;
`endif

    // Transfer control registers; memory array is deliberately not reset.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
`ifdef APB_MEM_PSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
`ifdef APB_MEM_PSTRB_EN
            strb_q   <= strb_d;
`endif
        end
    end

    // Next-state: capture the request in setup, count waits, finish or abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
`ifdef APB_MEM_PSTRB_EN
        strb_d   = strb_q;
`endif
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = PWAIT;
                    idx_d   = idx_in;
                    write_d = PWRITE;
                    err_d   = addr_err;
                    wdata_d = PWDATA;
`ifdef APB_MEM_PSTRB_EN
                    strb_d  = PSTRB;
`endif
                    // Read data is fetched at setup so it is stable for the
                    // whole access phase; writes leave PRDATA untouched.
                    if (!PWRITE) begin
                        prdata_d = addr_err ? '0 : mem[idx_in];
                    end
                end
            end
            ACCESS: begin
                // Losing PSEL/PENABLE before completion abandons the transfer.
                if (!(PSEL && PENABLE) || (cnt_q == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Write commits on the completing edge, byte lanes gated by the strobes.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
